eth_tx_arbiter: RTL and testbench
=================================

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter: IFG_BYTES, 12, idle bytes required between frames on the wire.
REQ-002 Parameter: PRE_BYTES, 8, preamble/SFD bytes the downstream preamble inserter adds to each frame.
REQ-003 Parameter: GNT_TIMEOUT, 16, cycles a grant is held waiting for the first data byte.
REQ-004 Parameter: MAX_BYTES, 1518, maximum forwarded bytes per frame.
REQ-005 Ports (name direction width meaning) SHALL be:
 i_clk  in  1  single clock, all logic on rising edge;
 i_rst  in  1  reset, asynchronous, active-high;
 i_req  in  2  frame request, bit n = requester n;
 o_gnt  out 2  one-hot grant, at most one bit set;
 i_data0  in  8  requester 0 byte;
 i_data_valid0  in  1  requester 0 byte valid;
 i_data1  in  8  requester 1 byte;
 i_data_valid1  in  1  requester 1 byte valid;
 o_data  out 8  byte to preamble inserter;
 o_data_valid  out 1  byte valid to preamble inserter;
 o_busy  out 1  high in any state other than IDLE;
 o_oversize  out 1  one-cycle pulse on frame truncation.

Function
REQ-006 States SHALL be IDLE, GRANT, SEND, DRAIN, GAP; all outputs registered.
REQ-007 IDLE: with any i_req bit set, the block SHALL set o_gnt for the winner on the next edge and enter GRANT.
REQ-008 Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; after reset requester 0 wins.
REQ-009 GRANT: first cycle the granted valid is high SHALL enter SEND and forward that byte.
REQ-010 GRANT: after GNT_TIMEOUT consecutive GRANT cycles without granted valid, o_gnt SHALL clear, state SHALL return to IDLE, and that requester SHALL count as last served.
REQ-011 SEND: o_data/o_data_valid SHALL equal the granted port's data/valid delayed exactly one cycle.
REQ-012 Non-granted data and valid SHALL be ignored in every state.
REQ-013 SEND: the first cycle granted valid is low SHALL end the frame: o_gnt cleared on that edge, gap counter loaded with IFG_BYTES+PRE_BYTES, state GAP.
REQ-014 A 16-bit byte counter SHALL count forwarded bytes; on a valid byte arriving with count already MAX_BYTES, that byte and all following SHALL be dropped (o_data_valid 0), o_oversize SHALL pulse one cycle, state DRAIN.
REQ-015 DRAIN: o_gnt SHALL stay set until granted valid goes low, then behave as REQ-013.
REQ-016 GAP: counter decrements each cycle; requests ignored; at zero state SHALL return to IDLE; minimum output idle between frames is IFG_BYTES+PRE_BYTES+1 cycles.
REQ-017 o_data SHALL be 8'h00 whenever o_data_valid is 0.
REQ-018 Request dropped while granted SHALL NOT abort GRANT/SEND; grant ends only per REQ-010/013/015.

Reset
REQ-019 i_rst high SHALL immediately force o_gnt=2'b00, o_data=8'h00, o_data_valid=0, o_busy=0, o_oversize=0, state IDLE, counters 0, round-robin pointer to favour requester 0, including mid-frame.
REQ-020 First grant after i_rst release SHALL occur no earlier than the first edge with i_rst low.

Verification
REQ-021 i_req=01, frame AA BB CC DD on port 0 -> o_gnt=01 one cycle later; o_data AA,BB,CC,DD each one cycle after input; o_gnt=00 the edge valid falls; o_busy low 20 cycles later.
REQ-022 i_req=11 held continuously, 4-byte frames -> grant order 0,1,0,1; o_data_valid low >=21 cycles between frames.
REQ-023 i_req=10, no valid on port 1 -> o_gnt=10 for 16 cycles then 00; with i_req=11 next grant is 01.
REQ-024 Port 0 frame of 1520 bytes -> 1518 bytes out, o_oversize one pulse, bytes 1519-1520 absent, GAP starts after input valid falls.
REQ-025 Port 1 valid toggling while port 0 granted -> o_data carries only port 0 bytes.
REQ-026 i_rst asserted at byte 2 of a frame -> all outputs 0 without clock edge; after release, i_req=11 grants 01.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Two-port round-robin transmit arbiter feeding a preamble inserter.
// A granted requester's bytes are forwarded with one cycle of latency.
// Frames longer than MAX_BYTES are truncated. After every frame the
// block holds off new grants for the interframe gap plus the preamble.
//
// Ports:
//   i_clk                        clock, rising edge
//   i_rst                        asynchronous active-high reset
//   i_req[1:0]                   frame request, bit n = requester n
//   o_gnt[1:0]                   one-hot grant
//   i_data0/i_data_valid0        requester 0 byte stream
//   i_data1/i_data_valid1        requester 1 byte stream
//   o_data/o_data_valid          forwarded byte stream (o_data is 0 when not valid)
//   o_busy                       high whenever the FSM is not in IDLE
//   o_oversize                   one-cycle pulse when a frame is truncated
//
// state | meaning
// IDLE  | waiting for a request; the grant is issued on the leaving edge
// GRANT | grant held, waiting for the first valid byte (bounded by GNT_TIMEOUT)
// SEND  | forwarding the granted stream, counting bytes
// DRAIN | frame truncated; discarding bytes until valid falls
// GAP   | grant released; counting down the interframe gap plus preamble
module eth_tx_arbiter #(
  parameter int IFG_BYTES   = 12,
  parameter int PRE_BYTES   = 8,
  parameter int GNT_TIMEOUT = 16,
  parameter int MAX_BYTES   = 1518
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  input  logic [7:0] i_data0,
  input  logic       i_data_valid0,
  input  logic [7:0] i_data1,
  input  logic       i_data_valid1,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_busy,
  output logic       o_oversize
);

  localparam logic [15:0] GAP_LOAD = 16'(IFG_BYTES + PRE_BYTES);
  localparam logic [15:0] TMO_LOAD = 16'(GNT_TIMEOUT - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic [7:0]  r_data;
  logic        r_data_valid;
  logic        r_busy;
  logic        r_oversize;
  logic        r_sel;      // index of the granted requester
  logic        r_last;     // last served requester; reset value 1 favours requester 0
  logic [15:0] r_byte_cnt;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_tmo_cnt;

  logic        w_gvalid;
  logic [7:0]  w_gdata;
  logic        w_winner;

  // Only the granted stream is ever looked at.
  assign w_gvalid = r_sel ? i_data_valid1 : i_data_valid0;
  assign w_gdata  = r_sel ? i_data1 : i_data0;

  // With both requesting, the one not served last wins.
  assign w_winner = (i_req == 2'b11) ? ~r_last : i_req[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 2'b00;
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_oversize   <= 1'b0;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_byte_cnt   <= 16'd0;
      r_gap_cnt    <= 16'd0;
      r_tmo_cnt    <= 16'd0;
    end else begin
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_oversize   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_sel     <= w_winner;
            r_last    <= w_winner;
            r_gnt     <= w_winner ? 2'b10 : 2'b01;
            r_tmo_cnt <= TMO_LOAD;
            r_busy    <= 1'b1;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_gvalid) begin
            r_data       <= w_gdata;
            r_data_valid <= 1'b1;
            r_byte_cnt   <= 16'd1;
            r_state      <= ST_SEND;
          end else if (r_tmo_cnt == 16'd0) begin
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - 16'd1;
          end
        end
        ST_SEND: begin
          if (!w_gvalid) begin
            r_gnt     <= 2'b00;
            r_gap_cnt <= GAP_LOAD;
            r_state   <= ST_GAP;
          end else if (r_byte_cnt == MAX_CNT) begin
            r_oversize <= 1'b1;
            r_state    <= ST_DRAIN;
          end else begin
            r_data       <= w_gdata;
            r_data_valid <= 1'b1;
            r_byte_cnt   <= r_byte_cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (!w_gvalid) begin
            r_gnt     <= 2'b00;
            r_gap_cnt <= GAP_LOAD;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Leaving on the edge the count reaches zero keeps o_busy high
          // for exactly IFG_BYTES+PRE_BYTES cycles after the grant drops.
          if (r_gap_cnt <= 16'd1) begin
            r_gap_cnt  <= 16'd0;
            r_byte_cnt <= 16'd0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end
        default: begin
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_busy       = r_busy;
  assign o_oversize   = r_oversize;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
// Directed bench for eth_tx_arbiter: reset behaviour, single frame timing,
// round-robin order with gap spacing, grant timeout, truncation, isolation
// of the non-granted port and asynchronous reset mid-frame.
module tb_eth_tx_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [7:0] d0, d1;
  logic       dv0, dv1;
  logic [7:0] o_data;
  logic       o_dv;
  logic       o_busy;
  logic       o_ovs;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  eth_tx_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .o_gnt         (gnt),
    .i_data0       (d0),
    .i_data_valid0 (dv0),
    .i_data1       (d1),
    .i_data_valid1 (dv1),
    .o_data        (o_data),
    .o_data_valid  (o_dv),
    .o_busy        (o_busy),
    .o_oversize    (o_ovs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic p, input logic [7:0] d, input logic v);
    if (p) begin
      d1 = d; dv1 = v;
    end else begin
      d0 = d; dv0 = v;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 2'b00; d0 = 8'h00; d1 = 8'h00; dv0 = 1'b0; dv1 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 2'b11; d0 = 8'h00; d1 = 8'h00; dv0 = 1'b0; dv1 = 1'b0;
    #3;
    n_checks++;
    if ({gnt, o_data, o_dv, o_busy, o_ovs} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b data=%h dv=%b busy=%b ovs=%b expected all 0",
               gnt, o_data, o_dv, o_busy, o_ovs);
    end
    tick;
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold_gnt: got %b expected 00", gnt);
    end
    rst = 1'b0;
    tick;
    n_checks++;
    if (gnt !== 2'b01 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant_after_reset: got gnt=%b busy=%b expected 01/1", gnt, o_busy);
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] b [4];
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset;
    req = 2'b01;
    tick;
    n_checks++;
    if (gnt !== 2'b01 || o_busy !== 1'b1 || o_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b busy=%b dv=%b expected 01/1/0", gnt, o_busy, o_dv);
    end
    req = 2'b00;  // dropping the request must not abort the grant
    for (int i = 0; i < 4; i++) begin
      d0 = b[i]; dv0 = 1'b1;
      tick;
      n_checks++;
      if (o_dv !== 1'b1 || o_data !== b[i] || gnt !== 2'b01) begin
        n_fail++;
        $display("FAIL single_byte%0d: got dv=%b data=%h gnt=%b expected 1/%h/01",
                 i, o_dv, o_data, gnt, b[i]);
      end
    end
    d0 = 8'h00; dv0 = 1'b0;
    tick;
    n_checks++;
    if (gnt !== 2'b00 || o_dv !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_end: got gnt=%b dv=%b data=%h busy=%b expected 00/0/00/1",
               gnt, o_dv, o_data, o_busy);
    end
    repeat (19) tick;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_busy_19: got %b expected 1", o_busy);
    end
    tick;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_busy_20: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_round_robin;
    int   last_cyc;
    int   waited;
    logic p;
    logic [7:0] exp_d;
    last_cyc = 0;
    do_reset;
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      waited = 0;
      while (gnt == 2'b00 && waited < 40) begin
        tick;
        waited++;
      end
      n_checks++;
      if (gnt !== ((f % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_grant_f%0d: got %b expected %b", f, gnt,
                 (f % 2 == 1) ? 2'b10 : 2'b01);
      end
      p = (f % 2 == 1);
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'(f * 16 + i + 1);
        drive(p, exp_d, 1'b1);
        tick;
        n_checks++;
        if (o_dv !== 1'b1 || o_data !== exp_d) begin
          n_fail++;
          $display("FAIL rr_f%0d_byte%0d: got dv=%b data=%h expected 1/%h", f, i, o_dv, o_data, exp_d);
        end
        if (i == 0 && f > 0) begin
          n_checks++;
          if (cyc - last_cyc - 1 < 21) begin
            n_fail++;
            $display("FAIL rr_gap_f%0d: got %0d idle cycles expected >= 21", f, cyc - last_cyc - 1);
          end
        end
      end
      last_cyc = cyc;
      drive(p, 8'h00, 1'b0);
      tick;
      n_checks++;
      if (gnt !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_end_f%0d: got gnt=%b expected 00", f, gnt);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_timeout;
    int held;
    do_reset;
    req = 2'b10;
    held = 0;
    tick;
    for (int i = 0; i < 16; i++) begin
      if (gnt === 2'b10) held++;
      if (i < 15) tick;
    end
    n_checks++;
    if (held != 16) begin
      n_fail++;
      $display("FAIL timeout_hold: got %0d cycles with gnt=10 expected 16", held);
    end
    tick;
    n_checks++;
    if (gnt !== 2'b00 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_release: got gnt=%b busy=%b expected 00/0", gnt, o_busy);
    end
    req = 2'b11;
    tick;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_next_grant: got %b expected 01", gnt);
    end
    req = 2'b00;
  endtask

  task automatic test_oversize;
    int good;
    int bad;
    int pulses;
    good = 0; bad = 0; pulses = 0;
    do_reset;
    req = 2'b01;
    tick;
    req = 2'b00;
    for (int i = 0; i < 1520; i++) begin
      d0 = 8'(i); dv0 = 1'b1;
      tick;
      if (o_ovs === 1'b1) pulses++;
      if (o_dv === 1'b1) begin
        good++;
        if (o_data !== 8'(i)) bad++;
      end
      if (i == 1518) begin
        n_checks++;
        if (o_ovs !== 1'b1 || o_dv !== 1'b0 || o_data !== 8'h00) begin
          n_fail++;
          $display("FAIL ovs_truncate: got ovs=%b dv=%b data=%h expected 1/0/00", o_ovs, o_dv, o_data);
        end
      end
      if (i == 1519) begin
        n_checks++;
        if (gnt !== 2'b01 || o_dv !== 1'b0 || o_ovs !== 1'b0) begin
          n_fail++;
          $display("FAIL ovs_drain: got gnt=%b dv=%b ovs=%b expected 01/0/0", gnt, o_dv, o_ovs);
        end
      end
    end
    n_checks++;
    if (good != 1518 || bad != 0) begin
      n_fail++;
      $display("FAIL ovs_count: got %0d bytes (%0d wrong) expected 1518 (0 wrong)", good, bad);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL ovs_pulses: got %0d expected 1", pulses);
    end
    d0 = 8'h00; dv0 = 1'b0;
    tick;
    n_checks++;
    if (gnt !== 2'b00 || o_busy !== 1'b1 || o_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL ovs_gap: got gnt=%b busy=%b dv=%b expected 00/1/0", gnt, o_busy, o_dv);
    end
  endtask

  task automatic test_ignore_other;
    logic [7:0] b [3];
    b = '{8'h11, 8'h22, 8'h33};
    do_reset;
    req = 2'b01;
    d1 = 8'hEE; dv1 = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      dv1 = ~dv1;
      d1 = 8'hE0 + 8'(i);
      tick;
      n_checks++;
      if (o_dv !== 1'b0 || o_data !== 8'h00 || gnt !== 2'b01) begin
        n_fail++;
        $display("FAIL other_idle%0d: got dv=%b data=%h gnt=%b expected 0/00/01", i, o_dv, o_data, gnt);
      end
    end
    for (int i = 0; i < 3; i++) begin
      d0 = b[i]; dv0 = 1'b1;
      dv1 = ~dv1; d1 = 8'hF0 + 8'(i);
      tick;
      n_checks++;
      if (o_dv !== 1'b1 || o_data !== b[i]) begin
        n_fail++;
        $display("FAIL other_byte%0d: got dv=%b data=%h expected 1/%h", i, o_dv, o_data, b[i]);
      end
    end
    d0 = 8'h00; dv0 = 1'b0; dv1 = 1'b1;
    tick;
    n_checks++;
    if (gnt !== 2'b00 || o_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL other_end: got gnt=%b dv=%b expected 00/0", gnt, o_dv);
    end
    dv1 = 1'b0;
  endtask

  task automatic test_reset_midframe;
    do_reset;
    req = 2'b01;
    tick;
    d0 = 8'h51; dv0 = 1'b1;
    tick;
    d0 = 8'h52;
    tick;
    n_checks++;
    if (o_dv !== 1'b1 || o_data !== 8'h52) begin
      n_fail++;
      $display("FAIL mid_byte2: got dv=%b data=%h expected 1/52", o_dv, o_data);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, o_data, o_dv, o_busy, o_ovs} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got gnt=%b data=%h dv=%b busy=%b ovs=%b expected all 0",
               gnt, o_data, o_dv, o_busy, o_ovs);
    end
    d0 = 8'h00; dv0 = 1'b0; req = 2'b11;
    tick;
    rst = 1'b0;
    tick;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_regrant: got %b expected 01", gnt);
    end
    req = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; d0 = 8'h00; d1 = 8'h00; dv0 = 1'b0; dv1 = 1'b0;
    test_reset;
    test_single_frame;
    test_round_robin;
    test_timeout;
    test_oversize;
    test_ignore_other;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
